fetch_pc_ifid: RTL and testbench
================================

Name: fetch_pc_ifid

Overview:
- Fetch stage of the MIPS pipeline: holds the program counter, drives `current_instruction_address` into mSomadorPC, and selects next PC from {PC+4, branch target, jump target}.
- Runs a request/ready handshake with instruction memory.
- Contains the IF/ID pipeline register that produces `somador_pc_plus_4_if_id`, consumed downstream by mSomadorBranch.
- Handles stall, redirect/flush and wait-state memory.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, instruction word inserted into IF/ID on bubble/flush (sll $0,$0,0).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- somador_pc_plus_4  in  32  PC+4 from mSomadorPC (= current_instruction_address+4).
- somador_branch_out  in  32  branch target from mSomadorBranch.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- jump_taken  in  1  jump resolved in ID this cycle.
- jump_target  in  32  jump destination.
- stall  in  1  hazard-unit stall: hold PC and IF/ID.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 until imem_ready.
- current_instruction_address  out  32  PC register.
- somador_pc_plus_4_if_id  out  32  IF/ID latched PC+4.
- instruction_if_id  out  32  IF/ID latched instruction.
- valid_if_id  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (synchronous, checked first every edge):
  - current_instruction_address=RESET_PC; somador_pc_plus_4_if_id=0; instruction_if_id=NOP_INSTR; valid_if_id=0.
  - hold buffer cleared; state=FETCH.
  - imem_req=0 while reset is high; the first request is in the cycle after reset deasserts.
  - Reset mid-request abandons the request; a late imem_ready from the aborted access is not possible, because memory shares the same reset.
- redirect = branch_taken | jump_taken. target = jump_target if jump_taken, else somador_branch_out (jump has priority if both are asserted).
- Redirect has priority over stall.
- States:
  - FETCH: imem_req=1, imem_addr=PC.
  - KILL: imem_req=1, imem_addr=kill_addr (latched old address); waits for the orphaned access to finish.
  - HOLD: imem_req=0; a fetched word is buffered while stall is active.
- FETCH transitions:
  - redirect & imem_ready: PC<=target; IF/ID flushed (valid=0, instr=NOP_INSTR, pc4=0); returned word discarded; stay FETCH.
  - redirect & !imem_ready: kill_addr<=PC; PC<=target; flush IF/ID; ->KILL.
  - !redirect & imem_ready & !stall: IF/ID<={somador_pc_plus_4, imem_rdata, valid=1}; PC<=somador_pc_plus_4; stay FETCH. Zero-wait memory sustains 1 instruction/cycle.
  - !redirect & imem_ready & stall: buffer<=imem_rdata; IF/ID and PC hold; ->HOLD.
  - !redirect & !imem_ready & !stall: IF/ID<=bubble (valid=0, instr=NOP_INSTR); PC holds; stay FETCH.
  - !redirect & !imem_ready & stall: IF/ID and PC hold; stay FETCH.
- KILL transitions:
  - imem_ready: discard the word; ->FETCH.
  - redirect in KILL: PC<=new target; kill_addr unchanged; stay (or leave on imem_ready).
  - IF/ID is bubble every non-stalled cycle in KILL.
- HOLD transitions:
  - redirect: drop buffer; PC<=target; flush IF/ID; ->FETCH.
  - !stall: IF/ID<={somador_pc_plus_4, buffer, 1}; PC<=somador_pc_plus_4; ->FETCH.
  - stall: hold everything.
- Arithmetic:
  - Arithmetic is all 32-bit unsigned wrap. PC 32'hFFFFFFFC + 4 gives 0; no flag.
  - PC bits [1:0] are never forced; misaligned targets pass through unchanged.
- Latency: an instruction fetched in cycle N appears on instruction_if_id in cycle N+1 (registered).

Test Plan:
- Reset with RESET_PC=0, imem_ready tied 1, no hazards -> imem_addr 0,4,8,12 on consecutive cycles; IF/ID pc4 = 4,8,12 one cycle later, valid=1 from the first post-reset edge onward.
- PC=0x40, imem_ready=1, branch_taken=1 with somador_branch_out=0x100 -> next cycle PC=0x100, valid_if_id=0, instruction_if_id=NOP; following cycle IF/ID pc4=0x104.
- PC=0x20, imem_ready low for 3 cycles, jump_taken=1 (jump_target=0x80) in the first of those cycles -> state KILL, imem_addr stays 0x20 until ready; word discarded; next request at 0x80; valid_if_id=0 throughout.
- imem_ready=1 at PC=0x10 with stall=1 for 2 cycles -> HOLD, imem_req=0, PC=0x10 held; on stall release IF/ID={0x14, buffered word, 1}, PC=0x14.
- stall=1 and branch_taken=1 in the same cycle (target 0x200) -> redirect wins: PC=0x200, IF/ID flushed.
- reset asserted during a pending request at PC=0x60 -> next edge PC=RESET_PC, valid_if_id=0, imem_req=0; fetching resumes from RESET_PC.

Source files
------------

// File: rtl/fetch_pc_ifid.sv
// MIPS fetch stage: PC, next-PC select, imem req/ready handshake and IF/ID register.
// Fetched word lands in IF/ID one cycle after imem_ready; stall freezes PC and IF/ID, redirect overrides stall.
module fetch_pc_ifid #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] somador_pc_plus_4,
    input  logic [31:0] somador_branch_out,
    input  logic        branch_taken,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] current_instruction_address,
    output logic [31:0] somador_pc_plus_4_if_id,
    output logic [31:0] instruction_if_id,
    output logic        valid_if_id
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_KILL  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] kill_addr_q,  kill_addr_d;
    logic [31:0] hold_buf_q,   hold_buf_d;
    logic [31:0] ifid_pc4_q,   ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_vld_q,   ifid_vld_d;

    logic        redirect;
    logic [31:0] target;

    assign redirect = branch_taken | jump_taken;
    assign target   = jump_taken ? jump_target : somador_branch_out;

    assign imem_req  = !reset && ((state_q == ST_FETCH) || (state_q == ST_KILL));
    // While killing, keep presenting the orphaned address so the memory sees a stable request.
    assign imem_addr = (state_q == ST_KILL) ? kill_addr_q : pc_q;

    assign current_instruction_address = pc_q;
    assign somador_pc_plus_4_if_id     = ifid_pc4_q;
    assign instruction_if_id           = ifid_instr_q;
    assign valid_if_id                 = ifid_vld_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_addr_d  = kill_addr_q;
        hold_buf_d   = hold_buf_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_vld_d   = ifid_vld_q;

        if (redirect) begin
            pc_d         = target;
            ifid_pc4_d   = 32'h0;
            ifid_instr_d = NOP_INSTR;
            ifid_vld_d   = 1'b0;
        end

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    if (!imem_ready) begin
                        kill_addr_d = pc_q;
                        state_d     = ST_KILL;
                    end
                end else if (imem_ready && !stall) begin
                    ifid_pc4_d   = somador_pc_plus_4;
                    ifid_instr_d = imem_rdata;
                    ifid_vld_d   = 1'b1;
                    pc_d         = somador_pc_plus_4;
                end else if (imem_ready) begin
                    hold_buf_d = imem_rdata;
                    state_d    = ST_HOLD;
                end else if (!stall) begin
                    ifid_pc4_d   = 32'h0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_vld_d   = 1'b0;
                end
            end
            ST_KILL: begin
                if (!redirect && !stall) begin
                    ifid_pc4_d   = 32'h0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_vld_d   = 1'b0;
                end
                if (imem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    hold_buf_d = 32'h0;
                    state_d    = ST_FETCH;
                end else if (!stall) begin
                    ifid_pc4_d   = somador_pc_plus_4;
                    ifid_instr_d = hold_buf_q;
                    ifid_vld_d   = 1'b1;
                    pc_d         = somador_pc_plus_4;
                    state_d      = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            kill_addr_q  <= 32'h0;
            hold_buf_q   <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_addr_q  <= kill_addr_d;
            hold_buf_q   <= hold_buf_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_vld_q   <= ifid_vld_d;
        end
    end

    a_addr_stable: assert property (@(posedge clock) disable iff (reset)
        (imem_req && !imem_ready) |=> (imem_addr == $past(imem_addr)));

    a_state_legal: assert property (@(posedge clock) disable iff (reset)
        (state_q != 2'd3));

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Directed bench for fetch_pc_ifid; imem returns {16'hC0DE, addr[15:0]} and PC adder is modelled as addr+4.
module tb_fetch_pc_ifid;

    localparam logic [31:0] NOP = 32'h00000000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] somador_pc_plus_4;
    logic [31:0] somador_branch_out;
    logic        branch_taken;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        stall;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] current_instruction_address;
    logic [31:0] somador_pc_plus_4_if_id;
    logic [31:0] instruction_if_id;
    logic        valid_if_id;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_pc_ifid #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .somador_pc_plus_4           (somador_pc_plus_4),
        .somador_branch_out          (somador_branch_out),
        .branch_taken                (branch_taken),
        .jump_taken                  (jump_taken),
        .jump_target                 (jump_target),
        .stall                       (stall),
        .imem_rdata                  (imem_rdata),
        .imem_ready                  (imem_ready),
        .imem_req                    (imem_req),
        .imem_addr                   (imem_addr),
        .current_instruction_address (current_instruction_address),
        .somador_pc_plus_4_if_id     (somador_pc_plus_4_if_id),
        .instruction_if_id           (instruction_if_id),
        .valid_if_id                 (valid_if_id)
    );

    always #5 clock = ~clock;

    // Environment: external PC adder and a memory whose data encodes the address.
    assign somador_pc_plus_4 = current_instruction_address + 32'd4;
    assign imem_rdata        = {16'hC0DE, imem_addr[15:0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [31:0] pc4, input logic [31:0] ins, input logic v);
        chk({tag, "_pc4"}, somador_pc_plus_4_if_id, pc4);
        chk({tag, "_ins"}, instruction_if_id, ins);
        chk({tag, "_vld"}, {31'b0, valid_if_id}, {31'b0, v});
    endtask

    task automatic jump_to(input logic [31:0] a);
        imem_ready  = 1'b1;
        jump_taken  = 1'b1;
        jump_target = a;
        tick();
        jump_taken  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; imem_ready = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; jump_taken = 1'b0;
        jump_target = 32'h0; somador_branch_out = 32'h0;
        tick(); tick();
        chk("rst_pc", current_instruction_address, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        ifid("rst", 32'h0, NOP, 1'b0);

        // Sequential zero-wait fetch
        reset = 1'b0;
        #1;
        chk("seq_req0", {31'b0, imem_req}, 32'h1);
        chk("seq_addr0", imem_addr, 32'h0);
        tick();
        chk("seq_addr4", imem_addr, 32'h4);
        ifid("seq1", 32'h4, 32'hC0DE0000, 1'b1);
        tick();
        chk("seq_addr8", imem_addr, 32'h8);
        ifid("seq2", 32'h8, 32'hC0DE0004, 1'b1);
        tick();
        chk("seq_addr12", imem_addr, 32'hC);
        ifid("seq3", 32'hC, 32'hC0DE0008, 1'b1);

        // Branch at PC=0x40 with ready memory
        jump_to(32'h40);
        chk("br_pc40", current_instruction_address, 32'h40);
        branch_taken = 1'b1; somador_branch_out = 32'h100;
        tick();
        branch_taken = 1'b0;
        chk("br_pc", current_instruction_address, 32'h100);
        ifid("br_flush", 32'h0, NOP, 1'b0);
        tick();
        ifid("br_next", 32'h104, 32'hC0DE0100, 1'b1);

        // Jump while memory is waiting -> KILL
        jump_to(32'h20);
        imem_ready = 1'b0; jump_taken = 1'b1; jump_target = 32'h80;
        #1;
        chk("kill_addr_pre", imem_addr, 32'h20);
        tick();
        jump_taken = 1'b0;
        chk("kill_pc", current_instruction_address, 32'h80);
        chk("kill_addr1", imem_addr, 32'h20);
        chk("kill_req", {31'b0, imem_req}, 32'h1);
        chk("kill_vld1", {31'b0, valid_if_id}, 32'h0);
        tick();
        chk("kill_addr2", imem_addr, 32'h20);
        chk("kill_vld2", {31'b0, valid_if_id}, 32'h0);
        tick();
        chk("kill_addr3", imem_addr, 32'h20);
        imem_ready = 1'b1;
        tick();
        chk("kill_resume", imem_addr, 32'h80);
        chk("kill_vld4", {31'b0, valid_if_id}, 32'h0);
        tick();
        ifid("kill_after", 32'h84, 32'hC0DE0080, 1'b1);

        // Stall with ready data -> HOLD
        jump_to(32'h10);
        stall = 1'b1;
        tick();
        chk("hold_req1", {31'b0, imem_req}, 32'h0);
        chk("hold_pc1", current_instruction_address, 32'h10);
        tick();
        chk("hold_req2", {31'b0, imem_req}, 32'h0);
        chk("hold_pc2", current_instruction_address, 32'h10);
        stall = 1'b0;
        tick();
        ifid("hold_rel", 32'h14, 32'hC0DE0010, 1'b1);
        chk("hold_pc3", current_instruction_address, 32'h14);
        chk("hold_addr", imem_addr, 32'h14);

        // Redirect beats stall
        stall = 1'b1; branch_taken = 1'b1; somador_branch_out = 32'h200;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        chk("rs_pc", current_instruction_address, 32'h200);
        ifid("rs_flush", 32'h0, NOP, 1'b0);

        // Wait-state bubble without stall
        tick();
        imem_ready = 1'b0;
        tick();
        chk("bub_pc", current_instruction_address, 32'h204);
        chk("bub_ins", instruction_if_id, NOP);
        chk("bub_vld", {31'b0, valid_if_id}, 32'h0);

        // PC wrap and misaligned target
        jump_to(32'hFFFFFFFC);
        tick();
        chk("wrap_pc", current_instruction_address, 32'h0);
        ifid("wrap", 32'h0, 32'hC0DEFFFC, 1'b1);
        jump_to(32'h33);
        chk("mis_pc", current_instruction_address, 32'h33);
        tick();
        chk("mis_pc4", somador_pc_plus_4_if_id, 32'h37);

        // Reset during pending request
        jump_to(32'h60);
        imem_ready = 1'b0;
        #1;
        chk("rr_req", {31'b0, imem_req}, 32'h1);
        chk("rr_addr", imem_addr, 32'h60);
        reset = 1'b1;
        #1;
        chk("rr_req_low", {31'b0, imem_req}, 32'h0);
        tick();
        chk("rr_pc", current_instruction_address, 32'h0);
        chk("rr_vld", {31'b0, valid_if_id}, 32'h0);
        reset = 1'b0; imem_ready = 1'b1;
        #1;
        chk("rr_addr0", imem_addr, 32'h0);
        tick();
        ifid("rr_resume", 32'h4, 32'hC0DE0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
